// File: rtl/serializer_fsm.sv
// Parallel-to-serial converter for the FIR output path: one-word holding register
// feeding a shift register so back-to-back words stream out without idle bits.
module serializer_fsm #(
    parameter int LENGTH    = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [LENGTH-1:0] iv_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic              o_dout,
    output logic              o_dout_valid,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy
);

    localparam int              CW       = $clog2(LENGTH) + 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(LENGTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_SHIFT = 2'b10
    } state_t;

    // Advance the shift register by one bit towards the serial output end.
    function automatic logic [LENGTH-1:0] shift_one(input logic [LENGTH-1:0] v);
        if (LSB_FIRST) begin
            shift_one = {1'b0, v[LENGTH-1:1]};
        end else begin
            shift_one = {v[LENGTH-2:0], 1'b0};
        end
    endfunction

    state_t              state_q, state_d;
    logic                hold_full_q, hold_full_d;
    logic [LENGTH-1:0]   hold_reg_q, hold_reg_d;
    logic [LENGTH-1:0]   shift_reg_q, shift_reg_d;
    logic [CW-1:0]       counter_q, counter_d;
    logic                valid_q, valid_d;
    logic                accept_s;
    logic                xfer_s;

    assign accept_s = i_en && i_din_valid && o_ready;
    assign xfer_s   = i_en && valid_q && i_ready;

    // Handshake and data outputs; everything reads 0 while reset is asserted.
    assign o_ready      = !i_rst && i_en && !hold_full_q;
    assign o_dout_valid = !i_rst && i_en && valid_q;
    assign o_dout       = !i_rst && (LSB_FIRST ? shift_reg_q[0] : shift_reg_q[LENGTH-1]);
    assign o_last       = !i_rst && valid_q && (counter_q == LAST_CNT);
    assign o_busy       = !i_rst && (hold_full_q || (state_q == ST_SHIFT));

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            hold_full_q <= 1'b0;
            hold_reg_q  <= {LENGTH{1'b0}};
            shift_reg_q <= {LENGTH{1'b0}};
            counter_q   <= CNT_ZERO;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_reg_q  <= hold_reg_d;
            shift_reg_q <= shift_reg_d;
            counter_q   <= counter_d;
            valid_q     <= valid_d;
        end
    end

    // Next-state logic: load from holding register, shift on transfers, refill holding register.
    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_reg_d  = hold_reg_q;
        shift_reg_d = shift_reg_q;
        counter_d   = counter_q;
        valid_d     = valid_q;

        if (i_en) begin
            case (state_q)
                ST_IDLE: begin
                    valid_d = 1'b0;
                    if (hold_full_q) begin
                        shift_reg_d = hold_reg_q;
                        hold_full_d = 1'b0;
                        counter_d   = CNT_ZERO;
                        valid_d     = 1'b1;
                        state_d     = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (xfer_s) begin
                        shift_reg_d = shift_one(shift_reg_q);
                        if (counter_q == LAST_CNT) begin
                            // Reload immediately when a word is waiting, so no bubble appears.
                            if (hold_full_q) begin
                                shift_reg_d = hold_reg_q;
                                hold_full_d = 1'b0;
                                counter_d   = CNT_ZERO;
                                valid_d     = 1'b1;
                                state_d     = ST_SHIFT;
                            end else begin
                                counter_d = CNT_ZERO;
                                valid_d   = 1'b0;
                                state_d   = ST_IDLE;
                            end
                        end else begin
                            counter_d = counter_q + CNT_ONE;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b0;
                    counter_d = CNT_ZERO;
                end
            endcase

            // Accept is only possible with the holding register empty, so it never
            // collides with a load in the same cycle.
            if (accept_s) begin
                hold_reg_d  = iv_din;
                hold_full_d = 1'b1;
            end else begin
                hold_reg_d = hold_reg_q;
            end
        end else begin
            state_d = state_q;
        end
    end

endmodule

// File: tb/tb_serializer_fsm.sv
// Self-checking bench for serializer_fsm: directed vector table, hand-written
// corner sequences and a randomized loopback against a word-level scoreboard.
module tb_serializer_fsm;

    localparam int LEN = 16;

    logic           clk;
    logic           rst;
    logic           en;
    logic [LEN-1:0] din;
    logic           dv;
    logic           rdy;
    logic           o_ready, o_dout, o_dout_valid, o_last, o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    serializer_fsm #(.LENGTH(LEN), .LSB_FIRST(1'b1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .iv_din       (din),
        .i_din_valid  (dv),
        .o_ready      (o_ready),
        .o_dout       (o_dout),
        .o_dout_valid (o_dout_valid),
        .o_last       (o_last),
        .i_ready      (rdy),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           rst, en, dv;
        logic [LEN-1:0] din;
        logic           rdy;
        logic           e_ready, e_valid, e_dout, e_last, e_busy;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; dv = 1'b0; rdy = 1'b1; din = 16'h0000;
        next_cycle();
        rst = 1'b0;
    endtask

    // Shared state for the sequences.
    logic [LEN-1:0] w0, w1, rx_word, word_a5;
    logic           accepted, acc2_done, started, prev_stall, prev_dout, prev_last, exp_bit;
    int             idx, nbits, nvalid_seen, sent, received, rx_nb, cyc;
    logic [LEN-1:0] acc_q[$];
    logic           pat[4];

    initial begin
        rst = 1'b1; en = 1'b1; dv = 1'b0; rdy = 1'b1; din = 16'h0000;
        #1;

        // ---------------- table-driven single word ----------------
        word_a5 = 16'hA5C3;
        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, word_a5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < LEN; k++) begin
            tbl[3+k] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1,
                         1'b1, 1'b1, word_a5[k], (k == LEN-1), 1'b1};
        end
        tbl[19] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int r = 0; r < 20; r++) begin
            rst = tbl[r].rst; en = tbl[r].en; dv = tbl[r].dv; din = tbl[r].din; rdy = tbl[r].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), o_ready,      tbl[r].e_ready);
            chk($sformatf("tbl%0d_valid", r), o_dout_valid, tbl[r].e_valid);
            chk($sformatf("tbl%0d_dout",  r), o_dout,       tbl[r].e_dout);
            chk($sformatf("tbl%0d_last",  r), o_last,       tbl[r].e_last);
            chk($sformatf("tbl%0d_busy",  r), o_busy,       tbl[r].e_busy);
            next_cycle();
        end

        // ---------------- back-to-back FFFF, 0001 ----------------
        do_reset();
        w0 = 16'hFFFF; w1 = 16'h0001;
        idx = 0; nbits = 0; acc2_done = 1'b0; started = 1'b0;
        for (int c = 0; c < 40; c++) begin
            dv = (idx < 2); din = (idx == 0) ? w0 : w1; rdy = 1'b1;
            @(negedge clk);
            accepted = dv && o_ready;
            if (acc2_done && nbits < LEN) chk("b2b_ready_low", o_ready, 1'b0);
            if (acc2_done && nbits == LEN) chk("b2b_ready_back", o_ready, 1'b1);
            if (started && nbits < 2*LEN) chk("b2b_no_gap", o_dout_valid, 1'b1);
            if (o_dout_valid) begin
                started = 1'b1;
                exp_bit = (nbits < LEN) ? 1'b1 : (nbits == LEN);
                chk($sformatf("b2b_bit%0d", nbits), o_dout, exp_bit);
                chk($sformatf("b2b_last%0d", nbits), o_last, (nbits % LEN) == LEN-1);
                nbits++;
            end
            next_cycle();
            if (accepted) begin
                if (idx == 1) acc2_done = 1'b1;
                idx++;
            end
        end
        chk("b2b_total_bits", nbits, 2*LEN);

        // ---------------- backpressure 8001 ----------------
        do_reset();
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        w0 = 16'h8001; idx = 0; nbits = 0; prev_stall = 1'b0; prev_dout = 1'b0; prev_last = 1'b0;
        for (int c = 0; c < 90; c++) begin
            dv = (idx == 0); din = w0; rdy = pat[c % 4];
            @(negedge clk);
            accepted = dv && o_ready;
            if (prev_stall) begin
                chk("bp_valid_hold", o_dout_valid, 1'b1);
                chk("bp_dout_hold",  o_dout, prev_dout);
                chk("bp_last_hold",  o_last, prev_last);
            end
            if (o_dout_valid && rdy) begin
                chk($sformatf("bp_bit%0d", nbits), o_dout, w0[nbits % LEN]);
                chk($sformatf("bp_last%0d", nbits), o_last, nbits == LEN-1);
                nbits++;
            end
            prev_stall = o_dout_valid && !rdy;
            prev_dout  = o_dout;
            prev_last  = o_last;
            next_cycle();
            if (accepted) idx++;
        end
        chk("bp_transfers", nbits, LEN);
        chk("bp_idle_busy", o_busy, 1'b0);

        // ---------------- reset mid-word ----------------
        do_reset();
        idx = 0; nbits = 0; cyc = 0;
        while (nbits < 5 && cyc < 50) begin
            dv = (idx < 2); din = (idx == 0) ? 16'h1234 : 16'hBEEF; rdy = 1'b1;
            @(negedge clk);
            accepted = dv && o_ready;
            if (o_dout_valid) begin
                chk($sformatf("rst_pre_bit%0d", nbits), o_dout, w0[0] & 1'b0 | (16'h1234 >> nbits) & 16'h0001);
                nbits++;
            end
            next_cycle();
            if (accepted) idx++;
            cyc++;
        end
        chk("rst_pre_bits", nbits, 5);
        chk("rst_held_accepted", idx, 2);
        rst = 1'b1; dv = 1'b0;
        @(negedge clk);
        chk("rst_ready", o_ready, 1'b0);
        chk("rst_valid", o_dout_valid, 1'b0);
        chk("rst_dout",  o_dout, 1'b0);
        chk("rst_last",  o_last, 1'b0);
        chk("rst_busy",  o_busy, 1'b0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_ready", o_ready, 1'b1);
        chk("rst_after_busy",  o_busy, 1'b0);
        nvalid_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_dout_valid) nvalid_seen++;
        end
        chk("rst_no_beef_bits", nvalid_seen, 0);

        // ---------------- enable gating ----------------
        do_reset();
        w0 = 16'h3C5A; idx = 0; nbits = 0; cyc = 0;
        while (nbits < LEN && cyc < 60) begin
            dv = (idx == 0); din = w0; rdy = 1'b1;
            if (nbits == 6 && en) begin
                // freeze for 3 cycles while a word is offered and the sink is ready
                en = 1'b0; dv = 1'b1; din = 16'hFFFF;
                for (int f = 0; f < 3; f++) begin
                    @(negedge clk);
                    chk("en_valid_off", o_dout_valid, 1'b0);
                    chk("en_ready_off", o_ready, 1'b0);
                    chk("en_dout_frozen", o_dout, w0[6]);
                    chk("en_busy_held", o_busy, 1'b1);
                    next_cycle();
                end
                en = 1'b1; dv = 1'b0;
            end
            @(negedge clk);
            accepted = dv && o_ready;
            if (o_dout_valid) begin
                chk($sformatf("en_bit%0d", nbits), o_dout, w0[nbits]);
                chk($sformatf("en_last%0d", nbits), o_last, nbits == LEN-1);
                nbits++;
            end
            next_cycle();
            if (accepted) idx++;
            cyc++;
        end
        chk("en_total_bits", nbits, LEN);
        for (int c = 0; c < 3; c++) next_cycle();
        @(negedge clk);
        chk("en_no_extra_word", o_busy, 1'b0);

        // ---------------- randomized loopback ----------------
        do_reset();
        acc_q.delete();
        sent = 0; received = 0; rx_nb = 0; rx_word = 16'h0000; cyc = 0;
        prev_stall = 1'b0; prev_dout = 1'b0; prev_last = 1'b0;
        while (received < 100 && cyc < 20000) begin
            en  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            dv  = (sent < 100) && ($urandom_range(0, 1) == 1);
            din = LEN'($urandom);
            @(negedge clk);
            chk("rnd_busy", o_busy, (acc_q.size() * LEN - rx_nb) != 0);
            if (!en) begin
                chk("rnd_en_ready", o_ready, 1'b0);
                chk("rnd_en_valid", o_dout_valid, 1'b0);
            end
            if (prev_stall) begin
                chk("rnd_stall_dout", o_dout, prev_dout);
                chk("rnd_stall_last", o_last, prev_last);
                if (en) chk("rnd_stall_valid", o_dout_valid, 1'b1);
            end
            if (dv && o_ready) begin
                acc_q.push_back(din);
                sent++;
            end
            if (o_dout_valid && rdy) begin
                chk("rnd_last", o_last, rx_nb == LEN-1);
                rx_word[rx_nb] = o_dout;
                rx_nb++;
                if (rx_nb == LEN) begin
                    if (acc_q.size() == 0) begin
                        chk("rnd_unexpected_word", 1, 0);
                    end else begin
                        chk($sformatf("rnd_word%0d", received), rx_word, acc_q.pop_front());
                    end
                    received++;
                    rx_nb = 0;
                end
            end
            prev_stall = o_dout_valid && !rdy;
            prev_dout  = o_dout;
            prev_last  = o_last;
            next_cycle();
            cyc++;
        end
        chk("rnd_words_received", received, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
